// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the signals exchanged between the pipeline datapath and the
//   hazard controller.
//   master : pipeline side. It drives register identifiers and EX/MEM/WB
//            status, and it consumes the stall, flush and forward controls.
//   slave  : hazard controller side.
//   Signals:
//     D_Rs1, D_Rs2        source registers of the instruction in ID
//     E_Rs1, E_Rs2, E_Rd  source/destination registers of the instruction in EX
//     E_ResultSrc         2'b01 marks a load in EX
//     E_PCSrc             taken branch or jump resolved in EX
//     E_DivStart          divide/remainder instruction present in EX
//     M_Rd, M_RegWrite    destination and write enable in MEM
//     W_Rd, W_RegWrite    destination and write enable in WB
//     F_Stall, D_Stall    hold PC / IF_ID
//     D_Flush             clear IF_ID
//     E_Stall, E_Flush    hold / clear ID_EX
//     M_Flush             clear EX_MEM
//     E_ForwardA/B        EX operand mux selects (00 RF, 01 WB, 10 MEM)
//     E_DivBusy           divide interlock active
//     E_DivDone           divide in its final cycle
//     StallCount          saturating count of F_Stall cycles
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           D_Rs1;
  logic [4:0]           D_Rs2;
  logic [4:0]           E_Rs1;
  logic [4:0]           E_Rs2;
  logic [4:0]           E_Rd;
  logic [1:0]           E_ResultSrc;
  logic                 E_PCSrc;
  logic                 E_DivStart;
  logic [4:0]           M_Rd;
  logic                 M_RegWrite;
  logic [4:0]           W_Rd;
  logic                 W_RegWrite;
  logic                 F_Stall;
  logic                 D_Stall;
  logic                 D_Flush;
  logic                 E_Stall;
  logic                 E_Flush;
  logic                 M_Flush;
  logic [1:0]           E_ForwardA;
  logic [1:0]           E_ForwardB;
  logic                 E_DivBusy;
  logic                 E_DivDone;
  logic [CNT_WIDTH-1:0] StallCount;

  modport master (
    output D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, E_ResultSrc, E_PCSrc,
           E_DivStart, M_Rd, M_RegWrite, W_Rd, W_RegWrite,
    input  F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush,
           E_ForwardA, E_ForwardB, E_DivBusy, E_DivDone, StallCount
  );

  modport slave (
    input  D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, E_ResultSrc, E_PCSrc,
           E_DivStart, M_Rd, M_RegWrite, W_Rd, W_RegWrite,
    output F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush,
           E_ForwardA, E_ForwardB, E_DivBusy, E_DivDone, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. It generates the flush, stall and forward
//   controls for the F, IF_ID, ID_EX and EX_MEM registers and for the EX
//   operand muxes. The controls come from the following logic:
//     - combinational load-use detection, branch/jump flush and forwarding
//     - a multi-cycle divide interlock (IDLE/BUSY/DONE FSM with a counter)
//     - a saturating count of cycles in which fetch was stalled
//   Parameters:
//     DIV_CYCLES  total EX occupancy of a divide, start cycle included (2..31)
//     CNT_WIDTH   width of StallCount; it must match the interface
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset. While it is low, every control
//            output is forced to 0.
//     hz     hazard_ctrl_if.slave. It carries all pipeline status and controls.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The start cycle is spent in IDLE, and the last cycle is spent in DONE.
  // BUSY therefore lasts DIV_CYCLES-2 cycles. The counter is loaded with the
  // number of BUSY cycles that remain after the first one. A 2-cycle divide
  // has no BUSY cycle, so it goes straight from IDLE to DONE.
  localparam logic [4:0] CNT_LOAD  = (DIV_CYCLES >= 3) ? 5'(DIV_CYCLES - 3) : 5'd0;
  localparam bit         SHORT_DIV = (DIV_CYCLES <= 2);

  div_state_e           state;
  div_state_e           state_next;
  logic [4:0]           cnt;
  logic [4:0]           cnt_next;
  logic [CNT_WIDTH-1:0] stall_count;

  logic                 div_hold;
  logic                 lw_stall;
  logic                 f_stall;
  logic                 d_stall;
  logic                 d_flush;
  logic                 e_stall;
  logic                 e_flush;
  logic                 m_flush;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 div_done;

  // A source operand takes the youngest in-flight result. MEM takes priority
  // over WB. A result for x0 is never forwarded because x0 always reads 0.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd,
    input logic       m_we,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
      return 2'b10;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Divide FSM: state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Divide FSM: next-state logic. BUSY and DONE ignore E_DivStart. The divide
  // is still in EX during those states, so it cannot restart itself.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (hz.E_DivStart) begin
          if (SHORT_DIV) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == 5'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Divide FSM and hazard outputs.
  // A divide occupying EX freezes everything upstream and sends a bubble into
  // MEM. While a divide is in EX, no branch can be resolving, and any
  // load-use hazard in ID is simply held. All outputs are gated by rst_n, so
  // they drop as soon as reset asserts, with no wait for a clock edge.
  always_comb begin
    div_hold = 1'b0;
    lw_stall = 1'b0;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_flush  = 1'b0;
    e_stall  = 1'b0;
    e_flush  = 1'b0;
    m_flush  = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    div_done = 1'b0;

    if (rst_n) begin
      div_hold = ((state == IDLE) && hz.E_DivStart) || (state == BUSY);
      div_done = (state == DONE);
      lw_stall = (hz.E_ResultSrc == 2'b01) && (hz.E_Rd != 5'd0) &&
                 ((hz.E_Rd == hz.D_Rs1) || (hz.E_Rd == hz.D_Rs2));
      fwd_a    = fwd_sel(hz.E_Rs1, hz.M_Rd, hz.M_RegWrite, hz.W_Rd, hz.W_RegWrite);
      fwd_b    = fwd_sel(hz.E_Rs2, hz.M_Rd, hz.M_RegWrite, hz.W_Rd, hz.W_RegWrite);

      if (div_hold) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_stall = 1'b1;
        m_flush = 1'b1;
      end else begin
        // A load-use hazard and a taken branch can occur in the same cycle.
        // In that case both stall and flush are raised. The redirected fetch
        // makes the flush the effective action.
        f_stall = lw_stall;
        d_stall = lw_stall;
        d_flush = hz.E_PCSrc;
        e_flush = lw_stall | hz.E_PCSrc;
      end
    end
  end

  // Performance counter: counts cycles with fetch stalled and holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (f_stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  assign hz.F_Stall    = f_stall;
  assign hz.D_Stall    = d_stall;
  assign hz.D_Flush    = d_flush;
  assign hz.E_Stall    = e_stall;
  assign hz.E_Flush    = e_flush;
  assign hz.M_Flush    = m_flush;
  assign hz.E_ForwardA = fwd_a;
  assign hz.E_ForwardB = fwd_b;
  assign hz.E_DivBusy  = div_hold;
  assign hz.E_DivDone  = div_done;
  assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. The main instance uses DIV_CYCLES=8 and
//   CNT_WIDTH=32. A second instance uses DIV_CYCLES=2 and CNT_WIDTH=4. It
//   exercises counter saturation and the shortest legal divide.
module tb_hazard_ctrl;

  typedef struct {
    string      name;
    logic [4:0] dRs1;
    logic [4:0] dRs2;
    logic [4:0] eRs1;
    logic [4:0] eRs2;
    logic [4:0] eRd;
    logic [1:0] eResultSrc;
    logic       ePCSrc;
    logic [4:0] mRd;
    logic       mRegWrite;
    logic [4:0] wRd;
    logic       wRegWrite;
    logic [5:0] expCtl;   // {F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush}
    logic [1:0] expFwdA;
    logic [1:0] expFwdB;
  } vector_t;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;
  int   expCount;

  vector_t vectors[13];

  hazard_ctrl_if #(.CNT_WIDTH(32)) hzIf ();
  hazard_ctrl_if #(.CNT_WIDTH(4))  satIf ();

  hazard_ctrl #(.DIV_CYCLES(8), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hzIf)
  );

  hazard_ctrl #(.DIV_CYCLES(2), .CNT_WIDTH(4)) dutSat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (satIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and logs a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packs the six stall/flush controls of the main DUT.
  function automatic logic [5:0] mainCtl();
    return {hzIf.F_Stall, hzIf.D_Stall, hzIf.D_Flush,
            hzIf.E_Stall, hzIf.E_Flush, hzIf.M_Flush};
  endfunction

  // Drives all main-DUT inputs to a quiet idle value.
  task automatic clearMain();
    hzIf.D_Rs1 = 5'd0; hzIf.D_Rs2 = 5'd0;
    hzIf.E_Rs1 = 5'd0; hzIf.E_Rs2 = 5'd0; hzIf.E_Rd = 5'd0;
    hzIf.E_ResultSrc = 2'b00; hzIf.E_PCSrc = 1'b0; hzIf.E_DivStart = 1'b0;
    hzIf.M_Rd = 5'd0; hzIf.M_RegWrite = 1'b0;
    hzIf.W_Rd = 5'd0; hzIf.W_RegWrite = 1'b0;
  endtask

  // Applies one table vector on the falling edge.
  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    hzIf.D_Rs1 = v.dRs1; hzIf.D_Rs2 = v.dRs2;
    hzIf.E_Rs1 = v.eRs1; hzIf.E_Rs2 = v.eRs2; hzIf.E_Rd = v.eRd;
    hzIf.E_ResultSrc = v.eResultSrc; hzIf.E_PCSrc = v.ePCSrc;
    hzIf.E_DivStart = 1'b0;
    hzIf.M_Rd = v.mRd; hzIf.M_RegWrite = v.mRegWrite;
    hzIf.W_Rd = v.wRd; hzIf.W_RegWrite = v.wRegWrite;
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    expCount  = 0;

    //                name           dRs1  dRs2  eRs1  eRs2  eRd   rsrc   pc    mRd   mWe   wRd   wWe   ctl        fA     fB
    vectors[0]  = '{"idle",         5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vectors[1]  = '{"lw_rs2",       5'd3, 5'd5, 5'd0, 5'd0, 5'd5, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b110010, 2'b00, 2'b00};
    vectors[2]  = '{"lw_rs1",       5'd5, 5'd9, 5'd0, 5'd0, 5'd5, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b110010, 2'b00, 2'b00};
    vectors[3]  = '{"lw_rd0_rs5",   5'd3, 5'd5, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vectors[4]  = '{"lw_rd0_rs0",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vectors[5]  = '{"alu_no_lu",    5'd3, 5'd5, 5'd0, 5'd0, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vectors[6]  = '{"src10_no_lu",  5'd3, 5'd5, 5'd0, 5'd0, 5'd5, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vectors[7]  = '{"fwd_mem_pri",  5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 6'b000000, 2'b10, 2'b00};
    vectors[8]  = '{"fwd_wb",       5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 6'b000000, 2'b01, 2'b00};
    vectors[9]  = '{"fwd_x0",       5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 6'b000000, 2'b00, 2'b00};
    vectors[10] = '{"fwd_split",    5'd0, 5'd0, 5'd4, 5'd9, 5'd0, 2'b00, 1'b0, 5'd9, 1'b1, 5'd4, 1'b1, 6'b000000, 2'b01, 2'b10};
    vectors[11] = '{"branch",       5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 6'b001010, 2'b00, 2'b00};
    vectors[12] = '{"branch_lw",    5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'b111010, 2'b00, 2'b00};

    // Reset with every hazard source active: all controls must stay 0.
    rst_n = 1'b0;
    hzIf.D_Rs1 = 5'd5; hzIf.D_Rs2 = 5'd5; hzIf.E_Rs1 = 5'd7; hzIf.E_Rs2 = 5'd7;
    hzIf.E_Rd = 5'd5; hzIf.E_ResultSrc = 2'b01; hzIf.E_PCSrc = 1'b1; hzIf.E_DivStart = 1'b1;
    hzIf.M_Rd = 5'd7; hzIf.M_RegWrite = 1'b1; hzIf.W_Rd = 5'd7; hzIf.W_RegWrite = 1'b1;
    satIf.D_Rs1 = 5'd0; satIf.D_Rs2 = 5'd0; satIf.E_Rs1 = 5'd0; satIf.E_Rs2 = 5'd0;
    satIf.E_Rd = 5'd0; satIf.E_ResultSrc = 2'b00; satIf.E_PCSrc = 1'b0; satIf.E_DivStart = 1'b0;
    satIf.M_Rd = 5'd0; satIf.M_RegWrite = 1'b0; satIf.W_Rd = 5'd0; satIf.W_RegWrite = 1'b0;
    #2;
    checkOutput("reset_ctl",   32'(mainCtl()), 32'd0);
    checkOutput("reset_fwdA",  32'(hzIf.E_ForwardA), 32'd0);
    checkOutput("reset_fwdB",  32'(hzIf.E_ForwardB), 32'd0);
    checkOutput("reset_busy",  32'(hzIf.E_DivBusy), 32'd0);
    checkOutput("reset_done",  32'(hzIf.E_DivDone), 32'd0);
    checkOutput("reset_count", hzIf.StallCount, 32'd0);
    @(negedge clk);
    clearMain();
    rst_n = 1'b1;

    // Combinational vector table. The StallCount model advances by each
    // vector's expected F_Stall, one rising edge per vector.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vectors[i]);
      #2;
      checkOutput({vectors[i].name, "_ctl"},  32'(mainCtl()), 32'(vectors[i].expCtl));
      checkOutput({vectors[i].name, "_fwdA"}, 32'(hzIf.E_ForwardA), 32'(vectors[i].expFwdA));
      checkOutput({vectors[i].name, "_fwdB"}, 32'(hzIf.E_ForwardB), 32'(vectors[i].expFwdB));
      checkOutput({vectors[i].name, "_count"}, hzIf.StallCount, 32'(expCount));
      expCount += int'(vectors[i].expCtl[5]);
    end

    // Divide with DIV_CYCLES=8: 7 held cycles, then DONE. A load-use hazard
    // present alongside the hold must not produce E_Flush.
    @(negedge clk);
    clearMain();
    hzIf.E_DivStart = 1'b1;
    hzIf.E_ResultSrc = 2'b01; hzIf.E_Rd = 5'd5; hzIf.D_Rs1 = 5'd5;
    for (int c = 0; c < 7; c++) begin
      #2;
      checkOutput($sformatf("div_hold_ctl_c%0d", c), 32'(mainCtl()), 32'b110101);
      checkOutput($sformatf("div_hold_busy_c%0d", c), 32'(hzIf.E_DivBusy), 32'd1);
      checkOutput($sformatf("div_hold_done_c%0d", c), 32'(hzIf.E_DivDone), 32'd0);
      checkOutput($sformatf("div_hold_count_c%0d", c), hzIf.StallCount, 32'(expCount));
      expCount++;
      @(negedge clk);
    end
    hzIf.E_ResultSrc = 2'b00; hzIf.E_Rd = 5'd0; hzIf.D_Rs1 = 5'd0;
    #2;
    checkOutput("div_done_ctl",  32'(mainCtl()), 32'd0);
    checkOutput("div_done_busy", 32'(hzIf.E_DivBusy), 32'd0);
    checkOutput("div_done_flag", 32'(hzIf.E_DivDone), 32'd1);
    @(negedge clk);
    hzIf.E_DivStart = 1'b0;
    #2;
    checkOutput("div_after_busy",  32'(hzIf.E_DivBusy), 32'd0);
    checkOutput("div_after_done",  32'(hzIf.E_DivDone), 32'd0);
    checkOutput("div_after_ctl",   32'(mainCtl()), 32'd0);
    checkOutput("div_after_count", hzIf.StallCount, 32'(expCount));
    checkOutput("div_count_is_10", hzIf.StallCount, 32'd10);

    // Reset during BUSY cycle 3 must drop everything without waiting for a clock edge.
    @(negedge clk);
    hzIf.E_DivStart = 1'b1;
    hzIf.M_Rd = 5'd7; hzIf.M_RegWrite = 1'b1; hzIf.E_Rs1 = 5'd7;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("mid_busy_estall", 32'(hzIf.E_Stall), 32'd1);
    checkOutput("mid_busy_fwdA",   32'(hzIf.E_ForwardA), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ctl",   32'(mainCtl()), 32'd0);
    checkOutput("mid_rst_busy",  32'(hzIf.E_DivBusy), 32'd0);
    checkOutput("mid_rst_fwdA",  32'(hzIf.E_ForwardA), 32'd0);
    checkOutput("mid_rst_count", hzIf.StallCount, 32'd0);
    @(negedge clk);
    clearMain();
    rst_n = 1'b1;
    expCount = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checkOutput($sformatf("post_rst_busy_c%0d", c), 32'(hzIf.E_DivBusy), 32'd0);
      checkOutput($sformatf("post_rst_done_c%0d", c), 32'(hzIf.E_DivDone), 32'd0);
      checkOutput($sformatf("post_rst_fstall_c%0d", c), 32'(hzIf.F_Stall), 32'd0);
      checkOutput($sformatf("post_rst_count_c%0d", c), hzIf.StallCount, 32'(expCount));
      @(negedge clk);
    end

    // Saturation on the 4-bit instance: a continuous load-use stall.
    satIf.E_ResultSrc = 2'b01; satIf.E_Rd = 5'd3; satIf.D_Rs2 = 5'd3;
    for (int i = 0; i < 23; i++) begin
      #2;
      checkOutput($sformatf("sat_count_i%0d", i), 32'(satIf.StallCount), (i > 15) ? 32'd15 : 32'(i));
      @(negedge clk);
    end
    checkOutput("sat_fstall", 32'(satIf.F_Stall), 32'd1);

    // Shortest divide (DIV_CYCLES=2): one held cycle, then DONE.
    satIf.E_ResultSrc = 2'b00; satIf.E_Rd = 5'd0; satIf.D_Rs2 = 5'd0;
    satIf.E_DivStart = 1'b1;
    #2;
    checkOutput("short_div_busy", 32'(satIf.E_DivBusy), 32'd1);
    checkOutput("short_div_mflush", 32'(satIf.M_Flush), 32'd1);
    @(negedge clk);
    #2;
    checkOutput("short_div_done", 32'(satIf.E_DivDone), 32'd1);
    checkOutput("short_div_busy2", 32'(satIf.E_DivBusy), 32'd0);
    @(negedge clk);
    satIf.E_DivStart = 1'b0;
    #2;
    checkOutput("short_div_idle", 32'(satIf.E_DivDone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
